// File: rtl/kalman_pkg.sv
// Shared types and constants for the scalar Kalman datapath.
// Build option: define KALMAN_ROUND_NEAREST_EN for round-to-nearest-even in fp32_mac.
package kalman_pkg;

  localparam int unsigned FP_W  = 32;
  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 24;

  typedef logic [FP_W-1:0] fp32_t;

  typedef enum logic [2:0] {
    IDLE,
    S_BU,
    S_AX,
    S_ERR,
    S_UPD,
    S_OUT
  } state_e;

  // Unpacked operand: hidden bit made explicit in man[23]
  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp_unp_t;

  localparam fp32_t FP_ZERO    = 32'h0000_0000;
  localparam fp32_t FP_ONE     = 32'h3F80_0000;
  localparam fp32_t FP_MAX_POS = 32'h7F7F_FFFF;

  localparam fp32_t A_COEF_DEF = FP_ONE;
  localparam fp32_t B_COEF_DEF = 32'h3E80_0000;
  localparam fp32_t H_COEF_DEF = FP_ONE;
  localparam fp32_t K_GAIN_DEF = 32'h3F00_0000;
  localparam fp32_t X_INIT_DEF = FP_ZERO;

  // Denormals become zero, Inf/NaN become max finite of the same sign
  function automatic fp_unp_t fp_unpack(input fp32_t v);
    fp_unp_t u;
    if (v[30:23] == 8'd0) begin
      u = '0;
    end else if (v[30:23] == 8'hFF) begin
      u = {v[31], FP_MAX_POS[30:23], 1'b1, FP_MAX_POS[22:0]};
    end else begin
      u = {v[31], v[30:23], 1'b1, v[22:0]};
    end
    return u;
  endfunction

endpackage

// File: rtl/fp32_mac.sv
// Combinational fp32 r = a*b + c with the product rounded before the add.
// Build option: KALMAN_ROUND_NEAREST_EN selects round-to-nearest-even, otherwise truncation.
module fp32_mac
  import kalman_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  output logic [31:0] r_c
);

  localparam int unsigned SUM_W = 57;

  fp_unp_t            ua, ub, uc, pu, big, sml, su;
  logic [47:0]        prod;
  logic [23:0]        pm;
  logic               pg, ps, p_rup;
  logic signed [10:0] pe;
  logic [7:0]         dexp;
  logic [SUM_W-1:0]   big_m, sml_m, sum, norm;
  logic [5:0]         lead;
  logic               sg, ss, s_rup;
  logic signed [10:0] se;
  logic               unused_c;

  // Apply rounding increment, then saturate overflow or flush underflow to +0
  function automatic fp_unp_t fp_finish(input logic s, input logic signed [10:0] e,
                                        input logic [23:0] m, input logic rup);
    logic [24:0]        m25;
    logic signed [10:0] ee;
    fp_unp_t            r;
    m25 = {1'b0, m} + 25'(rup);
    ee  = e;
    if (m25[24]) begin
      m25 = m25 >> 1;
      ee  = ee + 11'sd1;
    end
    if (ee <= 11'sd0) begin
      r = '0;
    end else if (ee >= 11'sd255) begin
      r = {s, FP_MAX_POS[30:23], 1'b1, FP_MAX_POS[22:0]};
    end else begin
      r = {s, ee[7:0], m25[23:0]};
    end
    return r;
  endfunction

  always_comb begin
    ua = fp_unpack(a);
    ub = fp_unpack(b);
    uc = fp_unpack(c);

    prod = 48'(ua.man) * 48'(ub.man);
    pe   = $signed({3'b000, ua.exp}) + $signed({3'b000, ub.exp}) - 11'sd127
         + $signed({10'b0, prod[47]});
    if (prod[47]) begin
      pm = prod[47:24];
      pg = prod[23];
      ps = |prod[22:0];
    end else begin
      pm = prod[46:23];
      pg = prod[22];
      ps = |prod[21:0];
    end
`ifdef KALMAN_ROUND_NEAREST_EN
    p_rup = pg & (ps | pm[0]);
`else
    p_rup = 1'b0;
`endif
    pu = fp_finish(ua.sign ^ ub.sign, pe, pm, p_rup);
    if (ua.exp == 8'd0 || ub.exp == 8'd0) pu = '0;

    // Addend aligned in a 57-bit frame so shifts up to 31 stay exact
    if ({pu.exp, pu.man} >= {uc.exp, uc.man}) begin
      big = pu;
      sml = uc;
    end else begin
      big = uc;
      sml = pu;
    end
    dexp  = big.exp - sml.exp;
    big_m = {1'b0, big.man, 32'b0};
    sml_m = (dexp > 8'd31) ? '0 : ({1'b0, sml.man, 32'b0} >> dexp);
    sum   = (big.sign == sml.sign) ? big_m + sml_m : big_m - sml_m;

    lead = '0;
    for (int i = 0; i < SUM_W; i++) begin
      if (sum[i]) lead = 6'(i);
    end
    norm = sum << (6'd56 - lead);
    se   = $signed({3'b000, big.exp}) + $signed({5'b00000, lead}) - 11'sd55;
    sg   = norm[32];
    ss   = |norm[31:0];
`ifdef KALMAN_ROUND_NEAREST_EN
    s_rup    = sg & (ss | norm[33]);
    unused_c = su.man[23];
`else
    s_rup    = 1'b0;
    unused_c = ^{su.man[23], pg, ps, sg, ss};
`endif
    su  = fp_finish(big.sign, se, norm[56:33], s_rup);
    r_c = (sum == '0) ? FP_ZERO : {su.sign, su.exp, su.man[22:0]};
  end

endmodule

// File: rtl/kalman_scalar_alu.sv
// Scalar steady-state Kalman filter: one shared fp32 MAC sequenced over five states.
// Build option: KALMAN_ROUND_NEAREST_EN (see fp32_mac) changes rounding only, not latency.
module kalman_scalar_alu
  import kalman_pkg::*;
#(
  parameter logic [31:0] A_COEF = A_COEF_DEF,
  parameter logic [31:0] B_COEF = B_COEF_DEF,
  parameter logic [31:0] H_COEF = H_COEF_DEF,
  parameter logic [31:0] K_GAIN = K_GAIN_DEF,
  parameter logic [31:0] X_INIT = X_INIT_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] uofk,
  input  logic [31:0] vrefofk,
  input  logic        uvalid,
  input  logic        Vrefofkvalid,
  output logic [31:0] Yout,
  output logic        Youtvalid,
  output logic        busy
);

  state_e      state_q, state_d;
  logic [31:0] x_q, x_d, t_q, t_d, xp_q, xp_d, e_q, e_d;
  logic [31:0] u_q, u_d, z_q, z_d, yout_q, yout_d;
  logic        youtvalid_q, youtvalid_d, busy_q, busy_d;
  logic [31:0] mac_a, mac_b, mac_c, mac_r_c;

  fp32_mac u_mac (
    .a   (mac_a),
    .b   (mac_b),
    .c   (mac_c),
    .r_c (mac_r_c)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= IDLE;
      x_q         <= X_INIT;
      t_q         <= FP_ZERO;
      xp_q        <= FP_ZERO;
      e_q         <= FP_ZERO;
      u_q         <= FP_ZERO;
      z_q         <= FP_ZERO;
      yout_q      <= FP_ZERO;
      youtvalid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      t_q         <= t_d;
      xp_q        <= xp_d;
      e_q         <= e_d;
      u_q         <= u_d;
      z_q         <= z_d;
      yout_q      <= yout_d;
      youtvalid_q <= youtvalid_d;
      busy_q      <= busy_d;
    end
  end

  // Next state, operand steering and result capture
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    t_d         = t_q;
    xp_d        = xp_q;
    e_d         = e_q;
    u_d         = u_q;
    z_d         = z_q;
    yout_d      = yout_q;
    youtvalid_d = 1'b0;
    mac_a       = FP_ZERO;
    mac_b       = FP_ZERO;
    mac_c       = FP_ZERO;
    unique case (state_q)
      IDLE: begin
        if (uvalid && Vrefofkvalid) begin
          u_d     = uofk;
          z_d     = vrefofk;
          state_d = S_BU;
        end
      end
      S_BU: begin
        mac_a   = B_COEF;
        mac_b   = u_q;
        t_d     = mac_r_c;
        state_d = S_AX;
      end
      S_AX: begin
        mac_a   = A_COEF;
        mac_b   = x_q;
        mac_c   = t_q;
        xp_d    = mac_r_c;
        state_d = S_ERR;
      end
      S_ERR: begin
        mac_a   = {~H_COEF[31], H_COEF[30:0]};
        mac_b   = xp_q;
        mac_c   = z_q;
        e_d     = mac_r_c;
        state_d = S_UPD;
      end
      S_UPD: begin
        mac_a   = K_GAIN;
        mac_b   = e_q;
        mac_c   = xp_q;
        x_d     = mac_r_c;
        state_d = S_OUT;
      end
      S_OUT: begin
        mac_a       = H_COEF;
        mac_b       = x_q;
        yout_d      = mac_r_c;
        youtvalid_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign Yout      = yout_q;
  assign Youtvalid = youtvalid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_kalman_scalar_alu.sv
// Directed, table-driven bench for kalman_scalar_alu with hand-computed fp32 results.
module tb_kalman_scalar_alu;

  logic        clock;
  logic        reset;
  logic [31:0] uofk;
  logic [31:0] vrefofk;
  logic        uvalid;
  logic        Vrefofkvalid;
  logic [31:0] Yout;
  logic        Youtvalid;
  logic        busy;

  int checks;
  int failures;

  typedef struct {
    logic [31:0] u;
    logic [31:0] z;
    logic [31:0] y;
  } vec_t;

  vec_t tbl [8];

  kalman_scalar_alu dut (
    .clock        (clock),
    .reset        (reset),
    .uofk         (uofk),
    .vrefofk      (vrefofk),
    .uvalid       (uvalid),
    .Vrefofkvalid (Vrefofkvalid),
    .Yout         (Yout),
    .Youtvalid    (Youtvalid),
    .busy         (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clock);
    reset = 1'b0;
    repeat (n) @(posedge clock);
    #1;
    chk("reset Yout", Yout, 32'h0);
    chk("reset Youtvalid", 32'(Youtvalid), 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    @(negedge clock);
    reset = 1'b1;
  endtask

  // One sample: checks busy, 5-cycle latency, result and single-cycle pulse
  task automatic run_sample(input logic [31:0] u, input logic [31:0] z,
                            input logic [31:0] y, input string name);
    int   lat;
    logic seen;
    @(negedge clock);
    uofk = u; vrefofk = z; uvalid = 1'b1; Vrefofkvalid = 1'b1;
    @(posedge clock);
    #1;
    uvalid = 1'b0; Vrefofkvalid = 1'b0;
    chk({name, " busy"}, 32'(busy), 32'h1);
    lat = 0; seen = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(posedge clock);
      #1;
      if (Youtvalid) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s timeout: got no Youtvalid expected one within 20 cycles", name);
    end else begin
      chk({name, " latency"}, 32'(lat), 32'd5);
      chk({name, " Yout"}, Yout, y);
      @(posedge clock);
      #1;
      chk({name, " pulse"}, 32'(Youtvalid), 32'h0);
      chk({name, " idle"}, 32'(busy), 32'h0);
    end
  endtask

  initial begin
    int pulses, busy_hi, nout;
    logic [31:0] b2b_exp [3];

    checks = 0; failures = 0;
    reset = 1'b0; uofk = '0; vrefofk = '0; uvalid = 1'b0; Vrefofkvalid = 1'b0;

    tbl[0] = '{32'h0000_0000, 32'h3F80_0000, 32'h3F00_0000};
    tbl[1] = '{32'h4000_0000, 32'h3F80_0000, 32'h3F80_0000};
    tbl[2] = '{32'h0000_0000, 32'h4040_0000, 32'h4000_0000};
    tbl[3] = '{32'h4080_0000, 32'h0000_0000, 32'h3FC0_0000};
    tbl[4] = '{32'h0000_0000, 32'hBF80_0000, 32'h3E80_0000};
    tbl[5] = '{32'h0000_0000, 32'h7F80_0000, 32'h7EFF_FFFF};
    tbl[6] = '{32'h0000_0000, 32'h7F80_0000, 32'h7F3F_FFFF};
    tbl[7] = '{32'h0000_0000, 32'hFF80_0000, 32'h7E7F_FFFE};
    b2b_exp[0] = 32'h3F00_0000;
    b2b_exp[1] = 32'h4088_0000;
    b2b_exp[2] = 32'h40C4_0000;

    do_reset(3);

    // Idle after reset: nothing moves
    pulses = 0; busy_hi = 0;
    repeat (10) begin
      @(posedge clock);
      #1;
      pulses  += 32'(Youtvalid);
      busy_hi += 32'(busy);
    end
    chk("idle pulses", 32'(pulses), 32'h0);
    chk("idle busy", 32'(busy_hi), 32'h0);
    chk("idle Yout", Yout, 32'h0);

    // Only one of the two valids: no acceptance
    pulses = 0; busy_hi = 0;
    @(negedge clock);
    uofk = 32'h4000_0000; vrefofk = 32'h3F80_0000; uvalid = 1'b1; Vrefofkvalid = 1'b0;
    repeat (3) begin
      @(posedge clock);
      #1;
      busy_hi += 32'(busy);
    end
    @(negedge clock);
    uvalid = 1'b0; Vrefofkvalid = 1'b1;
    repeat (3) begin
      @(posedge clock);
      #1;
      busy_hi += 32'(busy);
    end
    @(negedge clock);
    Vrefofkvalid = 1'b0;
    repeat (7) begin
      @(posedge clock);
      #1;
      pulses  += 32'(Youtvalid);
      busy_hi += 32'(busy);
    end
    chk("single valid busy", 32'(busy_hi), 32'h0);
    chk("single valid pulses", 32'(pulses), 32'h0);

    for (int i = 0; i < 8; i++) begin
      run_sample(tbl[i].u, tbl[i].z, tbl[i].y, $sformatf("vec%0d", i));
    end

    // Reset while in S_UPD aborts the update and restores x
    @(negedge clock);
    uofk = 32'h0; vrefofk = 32'h3F80_0000; uvalid = 1'b1; Vrefofkvalid = 1'b1;
    @(posedge clock);
    #1;
    uvalid = 1'b0; Vrefofkvalid = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("midreset Yout", Yout, 32'h0);
    chk("midreset busy", 32'(busy), 32'h0);
    chk("midreset Youtvalid", 32'(Youtvalid), 32'h0);
    @(negedge clock);
    reset = 1'b1;
    pulses = 0;
    repeat (6) begin
      @(posedge clock);
      #1;
      pulses += 32'(Youtvalid);
    end
    chk("midreset no pulse", 32'(pulses), 32'h0);
    run_sample(32'h0, 32'h3F80_0000, 32'h3F00_0000, "after midreset");

    // Low-order bits: exact results, then a truncated difference
    do_reset(1);
    run_sample(32'h0, 32'h3F80_0001, 32'h3F00_0001, "lsb exact");
    run_sample(32'h0, 32'h4000_0001, 32'h3FA0_0001, "lsb trunc");
    run_sample(32'h0040_0000, 32'h0000_0001, 32'h3F20_0001, "denormal in");

    // Back-to-back offers every cycle: only every 6th is taken
    do_reset(1);
    nout = 0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      @(negedge clock);
      uofk         = 32'h0;
      vrefofk      = (cyc == 0) ? 32'h3F80_0000 : 32'h4100_0000;
      uvalid       = (cyc < 18);
      Vrefofkvalid = (cyc < 18);
      @(posedge clock);
      #1;
      if (Youtvalid) begin
        if (nout < 3) chk($sformatf("b2b out%0d", nout), Yout, b2b_exp[nout]);
        chk($sformatf("b2b cycle%0d", nout), 32'(cyc), 32'(5 + 6 * nout));
        nout++;
      end
    end
    uvalid = 1'b0; Vrefofkvalid = 1'b0;
    chk("b2b count", 32'(nout), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/kalman_scalar_alu.md
Name: kalman_scalar_alu

Overview:
- Single-state (scalar) steady-state Kalman filter datapath operating on IEEE-754 single-precision words.
- Accepts a control input u(k) and a measurement vref(k), then updates the internal state estimate x.
- Presents the filtered output Yout = H*x.
- Top-level compute block of the Kalman subsystem. A single time-shared floating-point multiply-add unit is sequenced by an FSM.

Parameters:
- A_COEF, 32'h3F800000 (1.0): state transition coefficient.
- B_COEF, 32'h3E800000 (0.25): control input coefficient.
- H_COEF, 32'h3F800000 (1.0): observation coefficient.
- K_GAIN, 32'h3F000000 (0.5): steady-state Kalman gain.
- X_INIT, 32'h00000000 (0.0): state value loaded at reset.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous reset, active-low.
- uofk  in  32  control input u(k), fp32.
- vrefofk  in  32  measurement z(k), fp32.
- uvalid  in  1  uofk valid.
- Vrefofkvalid  in  1  vrefofk valid.
- Yout  out  32  filtered estimate H*x, fp32, registered.
- Youtvalid  out  1  one-cycle pulse when Yout updates.
- busy  out  1  high while the FSM is not in IDLE.

Behaviour:
- Reset (reset==0 at a clock edge) sets:
  - x=X_INIT, Yout=0, Youtvalid=0, busy=0, state=IDLE.
  - Reset mid-computation aborts the update; x keeps X_INIT.
- Acceptance: in IDLE, a cycle with uvalid && Vrefofkvalid latches u and z and moves to S_BU. If only one valid is high, nothing is accepted.
- Inputs presented while busy are dropped. There is no queue and no backpressure signal beyond busy.
- FSM and MAC operations: each state performs exactly one operation r = a*b + c in one cycle, registered.
  - S_BU: t = B*u + 0.
  - S_AX: xp = A*x + t.
  - S_ERR: e = (-H)*xp + z. The sign bit of H is flipped.
  - S_UPD: x = K*e + xp.
  - S_OUT: Yout = H*x + 0. Youtvalid=1 for this single cycle. Then return to IDLE.
- Latency: Yout/Youtvalid update at the 5th rising edge after the accepting edge. Minimum spacing between accepted samples is 6 cycles.
- MAC arithmetic (not fused):
  - The product is rounded to fp32, then added.
  - Denormal inputs are treated as zero. Denormal or underflowing results flush to +0.
  - Exact-zero sums give +0.
  - Overflow saturates to ±0x7F7FFFFF.
  - Exponent-255 inputs (Inf/NaN) are treated as ±max finite.
  - Rounding is truncation toward zero.
  - Alignment shifts beyond 31 bits contribute zero.

Optional Feature:
- KALMAN_ROUND_NEAREST_EN defined: the multiply and add stages round to nearest, ties-to-even, using guard/round/sticky bits.
- Undefined: truncation toward zero as above.
- Latency is identical in both builds.

Decomposition:
- Package kalman_pkg:
  - fp32 typedef.
  - FSM state enum: IDLE, S_BU, S_AX, S_ERR, S_UPD, S_OUT.
  - Constants FP_ZERO, FP_ONE, FP_MAX_POS and the default coefficient values.
- One sub-module, fp32_mac: purely combinational a*b+c under the arithmetic rules. The top level holds the FSM, the x/t/xp/e registers, operand muxing and the output register.

Test Plan:
- Hold reset low for 3 cycles -> Yout=0, Youtvalid=0, busy=0. Release, then idle 10 cycles -> no change.
- From reset, uofk=0, vrefofk=0x3F800000 (1.0), both valid for 1 cycle -> busy for 5 cycles, then Yout=0x3F000000 (0.5) with a single Youtvalid pulse.
- Then uofk=0x40000000 (2.0), vrefofk=0x3F800000 -> xp=1.0, e=0, Yout=0x3F800000.
- Then uofk=0, vrefofk=0x40400000 (3.0) -> Yout=0x40000000 (2.0).
- Present new valid samples every cycle, back-to-back, from reset:
  - First sample z=1.0, u=0; each following sample z=8.0, u=0.
  - Only cycles 0, 6, 12 … are accepted.
  - Yout sequence must be 0.5, 4.25, 6.125; Youtvalid count equals the accepted count.
- uvalid=1 with Vrefofkvalid=0 (and vice versa) -> no acceptance, busy stays 0.
- Assert reset during S_UPD -> next cycle Yout=0 and state IDLE. A following sample z=1.0, u=0 gives Yout=0x3F000000.
